// File: rtl/pooling_2d_sync_pkg.sv
// Shared helpers and parameter limits for the pooling_2d control-input synchronizer.
// Counter sizing, idle-level derivation and range checks live here.
package pooling_2d_sync_pkg;

   localparam int unsigned MAX_WIDTH         = 64;
   localparam int unsigned MIN_WIDTH         = 1;
   localparam int unsigned MIN_CYCLES        = 1;
   localparam int unsigned MIN_FILTER_CYCLES = 1;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Bit set in ACTIVE_HIGH means the channel idles low.
   function automatic logic [MAX_WIDTH-1:0] init_mask(input logic [MAX_WIDTH-1:0] active_high);
      return ~active_high;
   endfunction

   function automatic bit params_ok(input int unsigned width, input int unsigned cycles,
                                    input int unsigned filter_cycles);
      return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) && (cycles >= MIN_CYCLES) &&
             (filter_cycles >= MIN_FILTER_CYCLES);
   endfunction

endpackage

// File: rtl/pooling_2d_sync_chan.sv
// One synchronizer channel: flop chain, optional stability filter, registered edge pulses.
// The filter is built only when POOLING_2D_SYNC_FILTER_EN is defined.
module pooling_2d_sync_chan
   import pooling_2d_sync_pkg::*;
#(
   parameter int unsigned CYCLES        = 2,
`ifdef POOLING_2D_SYNC_FILTER_EN
   parameter int unsigned FILTER_CYCLES = 4,
`endif
   parameter logic        INIT          = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic sig_in,
   output logic sig_out,
   output logic rise,
   output logic fall
);

   logic [CYCLES:0] sync_q, sync_d;
   logic            out_q, next_out;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   always_comb begin
      sync_d = {sync_q[CYCLES-1:0], sig_in};
      if (clear) begin
         sync_d = {(CYCLES+1){INIT}};
      end
   end

`ifdef POOLING_2D_SYNC_FILTER_EN
   localparam int unsigned CW = cnt_width(FILTER_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Any sample equal to the current output restarts the stability count.
   always_comb begin
      next_out = out_q;
      cnt_d    = '0;
      if (clear) begin
         next_out = INIT;
      end else if (sync_q[CYCLES] != out_q) begin
         if (cnt_q == CNT_LAST) begin
            next_out = sync_q[CYCLES];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   always_comb begin
      next_out = clear ? INIT : sync_q[CYCLES];
   end
`endif

   // Clear forces idle without announcing it as an edge.
   always_comb begin
      rise_d = ~clear & next_out & ~out_q;
      fall_d = ~clear & ~next_out & out_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {(CYCLES+1){INIT}};
         out_q  <= INIT;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         out_q  <= next_out;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sig_out = out_q;
   assign rise    = rise_q;
   assign fall    = fall_q;

endmodule

// File: rtl/pooling_2d_sync_multi.sv
// Multi-channel synchronizer for asynchronous control inputs into the pooling_2d domain.
// Optional glitch filter enabled by defining POOLING_2D_SYNC_FILTER_EN.
module pooling_2d_sync_multi
   import pooling_2d_sync_pkg::*;
#(
   parameter int unsigned      WIDTH         = 4,
   parameter int unsigned      CYCLES        = 2,
   parameter logic [WIDTH-1:0] ACTIVE_HIGH   = {WIDTH{1'b1}},
   parameter int unsigned      FILTER_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] sig_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam logic [WIDTH-1:0] INIT = WIDTH'(init_mask(MAX_WIDTH'(ACTIVE_HIGH)));

   if (!params_ok(WIDTH, CYCLES, FILTER_CYCLES)) begin : g_bad_params
      $error("pooling_2d_sync_multi: WIDTH, CYCLES or FILTER_CYCLES out of range");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      pooling_2d_sync_chan #(
         .CYCLES        (CYCLES),
`ifdef POOLING_2D_SYNC_FILTER_EN
         .FILTER_CYCLES (FILTER_CYCLES),
`endif
         .INIT          (INIT[i])
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .clear   (clear),
         .sig_in  (sig_in[i]),
         .sig_out (sig_out[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   assign changed = |(rise | fall);

endmodule

// File: tb/tb_pooling_2d_sync_multi.sv
// Directed, table-driven bench for pooling_2d_sync_multi; expectations adapt to whether
// POOLING_2D_SYNC_FILTER_EN is defined.
module tb_pooling_2d_sync_multi;

   localparam int unsigned CYC = 2;
   localparam int unsigned FC  = 4;
`ifdef POOLING_2D_SYNC_FILTER_EN
   localparam int LAT     = CYC + FC;
   localparam int PRE_RST = 5;
`else
   localparam int LAT     = CYC + 1;
   localparam int PRE_RST = 2;
`endif

   logic       clk, reset_n;
   logic       clear_a, clear_b;
   logic [3:0] sin_a, sin_b;
   logic [3:0] out_a, rise_a, fall_a;
   logic [3:0] out_b, rise_b, fall_b;
   logic       changed_a, changed_b;

   int checks = 0;
   int errors = 0;

   pooling_2d_sync_multi #(
      .WIDTH         (4),
      .CYCLES        (CYC),
      .ACTIVE_HIGH   (4'b0101),
      .FILTER_CYCLES (FC)
   ) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear_a),
      .sig_in  (sin_a),
      .sig_out (out_a),
      .rise    (rise_a),
      .fall    (fall_a),
      .changed (changed_a)
   );

   pooling_2d_sync_multi #(
      .WIDTH         (4),
      .CYCLES        (CYC),
      .ACTIVE_HIGH   (4'b1111),
      .FILTER_CYCLES (FC)
   ) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear_b),
      .sig_in  (sin_b),
      .sig_out (out_b),
      .rise    (rise_b),
      .fall    (fall_b),
      .changed (changed_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] sin;
      logic [3:0] out;
      logic [3:0] rise;
      logic [3:0] fall;
      int         chg;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic next_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Accumulates which channels pulsed, repeated pulses and cycles with changed set.
   task automatic window(input int n, input bit sel_b, inout logic [3:0] rs,
                         inout logic [3:0] fs, inout int dup, inout int chg);
      logic [3:0] r, f;
      logic       c;
      for (int k = 0; k < n; k++) begin
         next_edge();
         r = sel_b ? rise_b : rise_a;
         f = sel_b ? fall_b : fall_a;
         c = sel_b ? changed_b : changed_a;
         if (((r & rs) != 4'b0) || ((f & fs) != 4'b0)) dup++;
         rs |= r;
         fs |= f;
         if (c) chg++;
      end
   endtask

   logic [3:0] rs, fs;
   int         dup, chg;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 0};
      vecs[1] = '{4'b1011, 4'b1011, 4'b0001, 4'b0000, 1};
      vecs[2] = '{4'b0111, 4'b0111, 4'b0100, 4'b1000, 1};
      vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0111, 1};
      vecs[4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 1};
      vecs[5] = '{4'b1010, 4'b1010, 4'b0000, 4'b0101, 1};

      reset_n = 1'b0;
      clear_a = 1'b0;
      clear_b = 1'b0;
      sin_a   = 4'b1010;
      sin_b   = 4'b0000;
      @(negedge clk);
      check("reset_out_a", out_a, 4'b1010);
      check("reset_out_b", out_b, 4'b0000);
      check("reset_pulses_a", rise_a | fall_a | {3'b0, changed_a}, 4'b0000);
      next_edge();
      reset_n = 1'b1;

      // Latency on channel 0 of dut_a (idle low).
      sin_a = 4'b1011;
      for (int k = 1; k <= LAT + 2; k++) begin
         next_edge();
         if (k == LAT) check("lat_before", {out_a[0], rise_a[0], 2'b00}, 4'b0000);
         if (k == LAT + 1) check("lat_edge", {out_a[0], rise_a[0], 2'b00}, 4'b1100);
         if (k == LAT + 2) check("lat_after", {out_a[0], rise_a[0], 2'b00}, 4'b1000);
      end
      sin_a = 4'b1010;
      rs = '0; fs = '0; dup = 0; chg = 0;
      window(LAT + 3, 1'b0, rs, fs, dup, chg);
      check("lat_restore_fall", fs, 4'b0001);

      // Mid-operation reset discards progress on dut_b channel 0.
      sin_b = 4'b0001;
      repeat (PRE_RST) next_edge();
      reset_n = 1'b0;
      #1;
      check("midrst_out_b", out_b, 4'b0000);
      check("midrst_out_a", out_a, 4'b1010);
      next_edge();
      reset_n = 1'b1;
      for (int k = 1; k <= LAT + 1; k++) begin
         next_edge();
         if (k == LAT) check("midrst_before", {out_b[0], rise_b[0], 2'b00}, 4'b0000);
         if (k == LAT + 1) check("midrst_edge", {out_b[0], rise_b[0], 2'b00}, 4'b1100);
      end
      sin_b = 4'b0000;
      rs = '0; fs = '0; dup = 0; chg = 0;
      window(LAT + 3, 1'b1, rs, fs, dup, chg);
      check("midrst_restore_fall", fs, 4'b0001);

      // Table of level changes on dut_a.
      for (int v = 0; v < 6; v++) begin
         sin_a = vecs[v].sin;
         rs = '0; fs = '0; dup = 0; chg = 0;
         window(LAT + 3, 1'b0, rs, fs, dup, chg);
         check($sformatf("vec%0d_out", v), out_a, vecs[v].out);
         check($sformatf("vec%0d_rise", v), rs, vecs[v].rise);
         check($sformatf("vec%0d_fall", v), fs, vecs[v].fall);
         check_int($sformatf("vec%0d_dup", v), dup, 0);
         check_int($sformatf("vec%0d_changed", v), chg, vecs[v].chg);
      end

      // Clear on dut_b while channel 2 falls.
      sin_b = 4'b1111;
      rs = '0; fs = '0; dup = 0; chg = 0;
      window(LAT + 3, 1'b1, rs, fs, dup, chg);
      check("clr_pre_out", out_b, 4'b1111);
      sin_b   = 4'b1011;
      clear_b = 1'b1;
      next_edge();
      clear_b = 1'b0;
      sin_b   = 4'b1111;
      check("clr_out", out_b, 4'b0000);
      check("clr_nofall", fall_b, 4'b0000);
      fs = '0;
      for (int k = 1; k <= LAT + 2; k++) begin
         next_edge();
         fs |= fall_b;
         if (k == LAT) check("clr_hold_idle", out_b, 4'b0000);
         if (k == LAT + 1) begin
            check("clr_rerise_out", out_b, 4'b1111);
            check("clr_rerise_pulse", rise_b, 4'b1111);
         end
      end
      check("clr_nofall_window", fs, 4'b0000);
      sin_b = 4'b0000;
      rs = '0; fs = '0; dup = 0; chg = 0;
      window(LAT + 3, 1'b1, rs, fs, dup, chg);
      check("clr_restore_fall", fs, 4'b1111);

`ifdef POOLING_2D_SYNC_FILTER_EN
      // Short pulses on channel 1 are rejected; a 5-cycle one passes.
      rs = '0; fs = '0; dup = 0; chg = 0;
      for (int p = 0; p < 2; p++) begin
         sin_b = 4'b0010;
         window(3, 1'b1, rs, fs, dup, chg);
         sin_b = 4'b0000;
         window(LAT + 3, 1'b1, rs, fs, dup, chg);
      end
      check("glitch3_rise", rs, 4'b0000);
      check("glitch3_fall", fs, 4'b0000);
      check("glitch3_out", out_b, 4'b0000);
      rs = '0; fs = '0; dup = 0; chg = 0;
      sin_b = 4'b0010;
      window(5, 1'b1, rs, fs, dup, chg);
      sin_b = 4'b0000;
      window(LAT + 3, 1'b1, rs, fs, dup, chg);
      check("pulse5_rise", rs, 4'b0010);
      check("pulse5_fall", fs, 4'b0010);
      check_int("pulse5_dup", dup, 0);
      check_int("pulse5_changed", chg, 2);

      // Toggling every cycle never settles.
      rs = '0; fs = '0; dup = 0; chg = 0;
      for (int t = 0; t < 24; t++) begin
         sin_b[1] = ~sin_b[1];
         window(1, 1'b1, rs, fs, dup, chg);
      end
      sin_b = 4'b0000;
      window(LAT + 3, 1'b1, rs, fs, dup, chg);
      check("toggle_rise", rs, 4'b0000);
      check("toggle_out", out_b, 4'b0000);
`else
      // A single-cycle pulse on channel 3 passes straight through.
      sin_b = 4'b1000;
      next_edge();
      sin_b = 4'b0000;
      for (int k = 2; k <= LAT + 3; k++) begin
         next_edge();
         if (k == LAT) check("nofilt_before", {out_b[3], rise_b[3], fall_b[3], 1'b0}, 4'b0000);
         if (k == LAT + 1) check("nofilt_high", {out_b[3], rise_b[3], fall_b[3], 1'b0}, 4'b1100);
         if (k == LAT + 2) check("nofilt_low", {out_b[3], rise_b[3], fall_b[3], 1'b0}, 4'b0010);
         if (k == LAT + 3) check("nofilt_idle", {out_b[3], rise_b[3], fall_b[3], 1'b0}, 4'b0000);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pooling_2d_sync_multi.md
# pooling_2d_sync_multi

Parametrised multi-channel synchronizer for asynchronous control inputs (start, mode, external flags) entering the pooling_2d clock domain. Each channel passes through a configurable multi-flop chain with per-channel idle polarity, an optional stability filter that rejects short glitches, and a registered edge detector. Outputs are the synchronized levels plus single-cycle rise/fall pulses, so downstream control logic needs no edge detection of its own.

## Interface
- WIDTH, 4: number of independent channels, ≥1.
- CYCLES, 2: synchronizer stages beyond the first; chain length is CYCLES+1, and CYCLES must be ≥1.
- ACTIVE_HIGH, {WIDTH{1'b1}}: per-channel mask. Bit=1 gives idle/reset level 0; bit=0 gives idle/reset level 1.
- FILTER_CYCLES, 4: number of consecutive equal samples required before a level change is accepted, ≥1. Used only when the filter is compiled in.
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear. Returns all state to idle levels.
- sig_in  input  WIDTH  asynchronous inputs.
- sig_out  output  WIDTH  synchronized, filtered levels.
- rise  output  WIDTH  one-cycle pulse per channel when sig_out goes 0→1.
- fall  output  WIDTH  one-cycle pulse per channel when sig_out goes 1→0.
- changed  output  1  OR of rise|fall.

## Operation
- Per channel i, the idle level is INIT[i] = ~ACTIVE_HIGH[i].
- Sync chain sync[CYCLES:0]:
  - sync[0] <= sig_in[i].
  - sync[k] <= sync[k-1].
- Filter (per channel), with counter cnt of width clog2(FILTER_CYCLES):
  - If sync[CYCLES]==out_q, then cnt<=0.
  - Else, if cnt==FILTER_CYCLES-1, then out_q<=sync[CYCLES] and cnt<=0.
  - Otherwise cnt<=cnt+1.
  - A mismatch shorter than FILTER_CYCLES samples never reaches sig_out. Any return to equality restarts the count.
- Edge pulses:
  - rise_q <= next_out & ~out_q.
  - fall_q <= ~next_out & out_q.
  - Pulses are asserted in the same cycle that sig_out first shows the new level.
- sig_out=out_q, rise=rise_q, fall=fall_q, changed=|(rise_q|fall_q). All outputs are registered.
- clear=1 (synchronous, highest priority):
  - Sync stages and out_q go to INIT.
  - cnt goes to 0.
  - rise/fall go to 0. No pulse is generated by the clear itself.
- Channels are fully independent. Simultaneous changes on several channels each produce their own pulse in their own cycle.

## Timing
- Reset values:
  - sig_out=INIT.
  - rise=0, fall=0, changed=0.
  - All sync stages=INIT, all cnt=0.
  - Registers carry the same values as power-up initial values.
- Latency: a change held stable from before clock edge E appears on sig_out after edge E+CYCLES+FILTER_CYCLES. The chain contributes CYCLES+1 edges; the filter contributes FILTER_CYCLES-1 further edges.
- A pulse lasts exactly 1 cycle.
- Minimum accepted pulse width at the input is FILTER_CYCLES clock periods, plus or minus 1 for sampling uncertainty.
- reset_n deassertion mid-operation: all channels restart from INIT. A later input level equal to INIT produces no pulse.
- An input toggling every cycle with FILTER_CYCLES≥2 must leave sig_out unchanged indefinitely.

## Configuration
- POOLING_2D_SYNC_FILTER_EN
  - Defined: the stability filter above is built with FILTER_CYCLES.
  - Undefined: FILTER_CYCLES is ignored. The filter reduces to a single register, out_q <= sync[CYCLES], and no counters exist. This is exactly equivalent to FILTER_CYCLES=1, giving latency CYCLES+1 edges.
  - Edge pulses and clear behave identically in both builds.

## Structure
- Shared package pooling_2d_sync_pkg holds:
  - function cnt_width(n), returning a minimum of 1 bit;
  - function init_mask(ACTIVE_HIGH), returning the INIT vector;
  - parameter-range check constants.
- One sub-module, pooling_2d_sync_chan, implements a single channel (chain, filter, edge registers). The top instantiates WIDTH copies in a generate loop and ORs the pulses into changed.

## Test plan
- Reset and idle:
  - Stimulus: WIDTH=4, ACTIVE_HIGH=4'b0101.
  - Required response: sig_out=4'b1010 during and after reset; rise, fall and changed stay 0 while sig_in holds 4'b1010.
- Latency:
  - Stimulus: CYCLES=2, FILTER_CYCLES=4; sig_in[0] steps 0→1 before edge 10.
  - Required response: sig_out[0]=1 and rise[0]=1 after edge 16 only; rise[0]=0 at edge 17.
- Glitch rejection:
  - Stimulus: FILTER_CYCLES=4; 3-cycle high pulses on sig_in[1], then a 5-cycle pulse.
  - Required response: the 3-cycle pulses give no change and no pulse; the 5-cycle pulse gives exactly one rise[1] and one fall[1].
- Clear:
  - Stimulus: sig_out=4'b1111 with ACTIVE_HIGH all 1; assert clear for 1 cycle while sig_in[2] falls.
  - Required response: sig_out=4'b0000 and no fall pulses; a held sig_in=4'b1111 re-rises after the full latency.
- Mid-operation reset:
  - Stimulus: assert reset_n low while a channel's cnt is 2.
  - Required response: the count is discarded; after release, the full FILTER_CYCLES sequence is required again.
- Filter compiled out:
  - Stimulus: POOLING_2D_SYNC_FILTER_EN undefined, CYCLES=2; a 1-cycle pulse, synchronous to clk, on sig_in[3].
  - Required response: sig_out[3] is high for 1 cycle, 3 edges later, with matching rise and fall pulses.
